// File: rtl/dbus_mem_responder_pkg.sv
// Shared data-bus types for the memory responders.
// Provides the request/response structs exchanged with the core's memory
// stage, the responder FSM state encoding and default memory-map constants.
package dbus_mem_responder_pkg;

  typedef logic [7:0] strobe_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    logic [2:0]  size;
    strobe_t     strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } resp_state_t;

  localparam logic [63:0] DMEM_BASE      = 64'h8000_0000;
  localparam int unsigned DMEM_ADDR_BITS = 12;
  localparam int unsigned DMEM_LATENCY   = 2;

endpackage

// File: rtl/dbus_mem_responder_dmem_array.sv
// dmem_array: 64-bit wide RAM, 2**ADDR_BITS words, byte-lane write enables.
// Ports:
//   clk    - write clock
//   we     - write request (qualified per lane by be)
//   be     - byte-lane enables, lane i covers bits [8*i+7:8*i]
//   idx    - word index, shared by read and write
//   wdata  - write word
//   rdata  - combinational read of mem[idx] (pre-write value in the write cycle)
// Contents are deliberately not reset.
module dmem_array
  import dbus_mem_responder_pkg::*;
#(
  parameter int unsigned ADDR_BITS = DMEM_ADDR_BITS
) (
  input  logic                 clk,
  input  logic                 we,
  input  strobe_t              be,
  input  logic [ADDR_BITS-1:0] idx,
  input  logic [63:0]          wdata,
  output logic [63:0]          rdata
);

  logic [63:0] mem_q [2**ADDR_BITS];

  assign rdata = mem_q[idx];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 8; i++) begin
      if (we && be[i]) begin
        mem_q[idx][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
  end

endmodule

// File: rtl/dbus_mem_responder.sv
// dbus_mem_responder: responder end of the core data bus backed by dmem_array.
// Accepts a request in IDLE (addr_ok combinational), waits LATENCY cycles and
// returns the pre-write word with a one-cycle data_ok. Writes land in the
// RESP cycle.
// Ports:
//   clk        - clock, all state on rising edge
//   reset      - asynchronous active-low reset of control state
//   dreq       - request from core (valid/addr/size/strobe/data)
//   dresp      - response to core (addr_ok/data_ok/data)
//   busy       - high whenever the FSM is not IDLE
//   proto_err  - sticky, requester changed valid/addr/strobe mid-transaction
//   range_err  - sticky, access outside [BASE, BASE + 8*2**ADDR_BITS)
//   done_cnt   - wrapping count of data_ok cycles
//
// state | meaning
// IDLE  | ready; accepts a request on dreq.valid
// WAIT  | counting down programmed latency
// RESP  | data_ok for one cycle, write committed
module dbus_mem_responder
  import dbus_mem_responder_pkg::*;
#(
  parameter int unsigned ADDR_BITS = DMEM_ADDR_BITS,
  parameter logic [63:0] BASE      = DMEM_BASE,
  parameter int unsigned LATENCY   = DMEM_LATENCY
) (
  input  logic        clk,
  input  logic        reset,
  input  dbus_req_t   dreq,
  output dbus_resp_t  dresp,
  output logic        busy,
  output logic        proto_err,
  output logic        range_err,
  output logic [31:0] done_cnt
);

  // Memory is indexed in 8-byte words; BASE is assumed word aligned.
  localparam logic [60:0] BASE_W = BASE[63:3];

  resp_state_t state_q, state_d;
  logic [3:0]  counter_q, counter_d;
  logic [63:0] addr_q, addr_d;
  strobe_t     strobe_q, strobe_d;
  logic [63:0] wdata_q, wdata_d;
  logic [2:0]  size_q, size_d;
  logic        proto_err_q, proto_err_d;
  logic        range_err_q, range_err_d;
  logic [31:0] done_cnt_q, done_cnt_d;

  logic [60:0]          word_off;
  logic                 in_range;
  logic                 hold_violation;
  logic                 mem_we;
  logic [63:0]          mem_rdata;
  logic [ADDR_BITS-1:0] mem_idx;

  // Size is latched for visibility only: the full word is always returned and
  // lane extraction happens in the core.
  logic unused_size;
  assign unused_size = ^size_q;

  assign word_off = addr_q[63:3] - BASE_W;
  assign in_range = (addr_q[63:3] >= BASE_W) && (word_off[60:ADDR_BITS] == '0);
  assign mem_idx  = word_off[ADDR_BITS-1:0];

  assign hold_violation = !dreq.valid
                        || (dreq.addr != addr_q)
                        || (dreq.strobe != strobe_q);

  dmem_array #(
    .ADDR_BITS (ADDR_BITS)
  ) u_dmem_array (
    .clk   (clk),
    .we    (mem_we),
    .be    (strobe_q),
    .idx   (mem_idx),
    .wdata (wdata_q),
    .rdata (mem_rdata)
  );

  always_comb begin
    state_d     = state_q;
    counter_d   = counter_q;
    addr_d      = addr_q;
    strobe_d    = strobe_q;
    wdata_d     = wdata_q;
    size_d      = size_q;
    proto_err_d = proto_err_q;
    range_err_d = range_err_q;
    done_cnt_d  = done_cnt_q;
    mem_we      = 1'b0;
    dresp       = '0;

    unique case (state_q)
      IDLE: begin
        // addr_ok is combinational, so hold it low while reset is asserted.
        if (dreq.valid && reset) begin
          dresp.addr_ok = 1'b1;
          addr_d        = dreq.addr;
          strobe_d      = dreq.strobe;
          wdata_d       = dreq.data;
          size_d        = dreq.size;
          counter_d     = 4'(LATENCY);
          state_d       = (LATENCY == 0) ? RESP : WAIT;
        end
      end

      WAIT: begin
        counter_d = counter_q - 4'd1;
        if (counter_q <= 4'd1) begin
          state_d = RESP;
        end
        if (hold_violation) begin
          proto_err_d = 1'b1;
        end
      end

      RESP: begin
        dresp.data_ok = 1'b1;
        dresp.data    = in_range ? mem_rdata : 64'd0;
        mem_we        = in_range && (strobe_q != '0);
        if (!in_range) begin
          range_err_d = 1'b1;
        end
        if (hold_violation) begin
          proto_err_d = 1'b1;
        end
        done_cnt_d = done_cnt_q + 32'd1;
        state_d    = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      counter_q   <= '0;
      addr_q      <= '0;
      strobe_q    <= '0;
      wdata_q     <= '0;
      size_q      <= '0;
      proto_err_q <= 1'b0;
      range_err_q <= 1'b0;
      done_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      counter_q   <= counter_d;
      addr_q      <= addr_d;
      strobe_q    <= strobe_d;
      wdata_q     <= wdata_d;
      size_q      <= size_d;
      proto_err_q <= proto_err_d;
      range_err_q <= range_err_d;
      done_cnt_q  <= done_cnt_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign proto_err = proto_err_q;
  assign range_err = range_err_q;
  assign done_cnt  = done_cnt_q;

endmodule
